// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back stage of the 8-bit RISC pipeline.
// Latency: 1 cycle for non-memory ops, WAIT_CYCLES+1 cycles for loads/stores.
// Backpressure: mem_stall (combinational) holds EXE/MEM while an access is in flight.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   exe_mem_valid/out/sdata/rd    EXE/MEM payload (out[ADDR_W-1:0] is the memory address)
//   exe_mem_memrd/memwr/regwr     load / store / register-write controls
//   mem_stall                     upstream hold request
//   rf_we/rf_waddr/rf_wdata       registered MEM/WB register-file write port
//   fwd_valid/fwd_rd/fwd_data     combinational ALU-result bypass (only with MEM_FWD_EN)
//
// Optional feature macro: MEM_FWD_EN (adds the fwd_* outputs).

module mem_wb_stage #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned RADDR_W     = 3,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               exe_mem_valid,
  input  logic [DATA_W-1:0]  exe_mem_out,
  input  logic [DATA_W-1:0]  exe_mem_sdata,
  input  logic [RADDR_W-1:0] exe_mem_rd,
  input  logic               exe_mem_memrd,
  input  logic               exe_mem_memwr,
  input  logic               exe_mem_regwr,
  output logic               mem_stall,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata
`ifdef MEM_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data
`endif
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
  // Counter preload; the zero-wait build never enters BUSY so its value is irrelevant there.
  localparam logic [2:0] CNT_INIT = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  // Operation captured on acceptance; the full ALU result is kept because it
  // carries both the address and the write-back value for a memrd+memwr op.
  logic [DATA_W-1:0]  op_out;
  logic [DATA_W-1:0]  op_sdata;
  logic [RADDR_W-1:0] op_rd;
  logic               op_memrd;
  logic               op_memwr;
  logic               op_regwr;

  logic               memop;
  logic               op_ld;
  logic               wb_upd;
  logic               acc_mem;
  logic               use_op;

  logic [DATA_W-1:0]  acc_out;
  logic [DATA_W-1:0]  acc_sdata;
  logic [RADDR_W-1:0] acc_rd;
  logic               acc_memrd;
  logic               acc_memwr;
  logic               acc_regwr;
  logic [ADDR_W-1:0]  acc_addr;
  logic               acc_st;
  logic               acc_ld_wb;
  logic [DATA_W-1:0]  wdata_nxt;

  assign memop = exe_mem_valid & (exe_mem_memrd | exe_mem_memwr);

  // Next-state, stall and access-select logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_stall = 1'b0;
    op_ld     = 1'b0;
    wb_upd    = 1'b0;
    acc_mem   = 1'b0;
    use_op    = 1'b0;
    if (state == IDLE) begin
      if (exe_mem_valid) begin
        if (!memop) begin
          wb_upd = 1'b1;
        end else if (!HAS_WAIT) begin
          wb_upd  = 1'b1;
          acc_mem = 1'b1;
        end else begin
          op_ld     = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = BUSY;
          mem_stall = 1'b1;
        end
      end
    end else begin
      // BUSY: EXE/MEM is ignored until the completion edge.
      if (cnt != 3'd0) begin
        cnt_nxt   = cnt - 3'd1;
        mem_stall = 1'b1;
      end else begin
        wb_upd    = 1'b1;
        acc_mem   = 1'b1;
        use_op    = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  // Access fields come straight from EXE/MEM, or from the op register on BUSY completion.
  always_comb begin
    acc_out   = exe_mem_out;
    acc_sdata = exe_mem_sdata;
    acc_rd    = exe_mem_rd;
    acc_memrd = exe_mem_memrd;
    acc_memwr = exe_mem_memwr;
    acc_regwr = exe_mem_regwr;
    if (use_op) begin
      acc_out   = op_out;
      acc_sdata = op_sdata;
      acc_rd    = op_rd;
      acc_memrd = op_memrd;
      acc_memwr = op_memwr;
      acc_regwr = op_regwr;
    end
  end

  // Upper address bits are dropped, so addresses wrap modulo DEPTH.
  assign acc_addr  = acc_out[ADDR_W-1:0];
  assign acc_st    = acc_mem & acc_memwr;
  // memrd+memwr together is a store; write-back then carries the ALU result.
  assign acc_ld_wb = acc_mem & acc_memrd & ~acc_memwr;
  assign wdata_nxt = acc_ld_wb ? mem[acc_addr] : acc_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      op_out   <= '0;
      op_sdata <= '0;
      op_rd    <= '0;
      op_memrd <= 1'b0;
      op_memwr <= 1'b0;
      op_regwr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (op_ld) begin
        op_out   <= exe_mem_out;
        op_sdata <= exe_mem_sdata;
        op_rd    <= exe_mem_rd;
        op_memrd <= exe_mem_memrd;
        op_memwr <= exe_mem_memwr;
        op_regwr <= exe_mem_regwr;
      end
      if (wb_upd) begin
        rf_we    <= acc_regwr;
        rf_waddr <= acc_rd;
        rf_wdata <= wdata_nxt;
      end else begin
        // Bubble or wait cycle: address and data hold, only the enable drops.
        rf_we <= 1'b0;
      end
      if (acc_st) begin
        mem[acc_addr] <= acc_sdata;
      end
    end
  end

`ifdef MEM_FWD_EN
  // Loads are excluded: their data is not known until the access completes.
  assign fwd_valid = (state == IDLE) & exe_mem_valid & exe_mem_regwr & ~exe_mem_memrd;
  assign fwd_rd    = exe_mem_rd;
  assign fwd_data  = exe_mem_out;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
// Two instances share stimulus: u_w1 (WAIT_CYCLES=1) and u_w3 (WAIT_CYCLES=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.

module tb_mem_wb_stage;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       exe_mem_valid;
  logic [7:0] exe_mem_out;
  logic [7:0] exe_mem_sdata;
  logic [2:0] exe_mem_rd;
  logic       exe_mem_memrd;
  logic       exe_mem_memwr;
  logic       exe_mem_regwr;

  logic       stall1, we1, stall3, we3;
  logic [2:0] waddr1, waddr3;
  logic [7:0] wdata1, wdata3;
`ifdef MEM_FWD_EN
  logic       fvld1, fvld3;
  logic [2:0] frd1, frd3;
  logic [7:0] fdat1, fdat3;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(8), .ADDR_W(4), .RADDR_W(3), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset_n(reset_n),
    .exe_mem_valid(exe_mem_valid), .exe_mem_out(exe_mem_out),
    .exe_mem_sdata(exe_mem_sdata), .exe_mem_rd(exe_mem_rd),
    .exe_mem_memrd(exe_mem_memrd), .exe_mem_memwr(exe_mem_memwr),
    .exe_mem_regwr(exe_mem_regwr),
    .mem_stall(stall1), .rf_we(we1), .rf_waddr(waddr1), .rf_wdata(wdata1)
`ifdef MEM_FWD_EN
    , .fwd_valid(fvld1), .fwd_rd(frd1), .fwd_data(fdat1)
`endif
  );

  mem_wb_stage #(.DATA_W(8), .ADDR_W(4), .RADDR_W(3), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset_n(reset_n),
    .exe_mem_valid(exe_mem_valid), .exe_mem_out(exe_mem_out),
    .exe_mem_sdata(exe_mem_sdata), .exe_mem_rd(exe_mem_rd),
    .exe_mem_memrd(exe_mem_memrd), .exe_mem_memwr(exe_mem_memwr),
    .exe_mem_regwr(exe_mem_regwr),
    .mem_stall(stall3), .rf_we(we3), .rf_waddr(waddr3), .rf_wdata(wdata3)
`ifdef MEM_FWD_EN
    , .fwd_valid(fvld3), .fwd_rd(frd3), .fwd_data(fdat3)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] out, input logic [7:0] sd,
                       input logic [2:0] rd, input logic mr, input logic mw, input logic rw);
    exe_mem_valid = v;
    exe_mem_out   = out;
    exe_mem_sdata = sd;
    exe_mem_rd    = rd;
    exe_mem_memrd = mr;
    exe_mem_memwr = mw;
    exe_mem_regwr = rw;
  endtask

  task automatic drive_idle();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic sel_stall(input bit use3);
    return use3 ? stall3 : stall1;
  endfunction

  function automatic logic sel_we(input bit use3);
    return use3 ? we3 : we1;
  endfunction

  // Presents a memop (already driven by the caller), counts stalled cycles,
  // checks rf_we stays low while waiting, then passes the completion edge.
  // Inputs are left as they are so the caller can chain a back-to-back op.
  task automatic run_memop(input string tag, input bit use3, input int exp_stall);
    int cyc;
    int stalled;
    stalled = 0;
    cyc     = 0;
    #1;
    while (sel_stall(use3) === 1'b1 && cyc < 16) begin
      if (cyc > 0) check_eq({tag, "_we_wait"}, 32'(sel_we(use3)), 32'd0);
      stalled++;
      cyc++;
      tick();
    end
    if (cyc >= 16) check_eq({tag, "_stall_bound"}, 32'd1, 32'd0);
    check_eq({tag, "_stall_cycles"}, 32'(stalled), 32'(exp_stall));
    check_eq({tag, "_we_last_wait"}, 32'(sel_we(use3)), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    drive_idle();
    reset_n = 1'b0;
    #1;
    // Reset state.
    tick();
    check_eq("rst_we_during", 32'(we1), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("rst_we", 32'(we1), 32'd0);
    check_eq("rst_waddr", 32'(waddr1), 32'd0);
    check_eq("rst_wdata", 32'(wdata1), 32'd0);
    check_eq("rst_stall", 32'(stall1), 32'd0);

    // Load from cleared memory address 5.
    drive(1'b1, 8'h05, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
    run_memop("ld5", 1'b0, 1);
    drive_idle();
    check_eq("ld5_we", 32'(we1), 32'd1);
    check_eq("ld5_waddr", 32'(waddr1), 32'd2);
    check_eq("ld5_wdata", 32'(wdata1), 32'h00);

    // ALU op: one-cycle latency, no stall.
    drive(1'b1, 8'h2A, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1);
    #1;
    check_eq("alu_stall", 32'(stall1), 32'd0);
`ifdef MEM_FWD_EN
    check_eq("alu_fwd_valid", 32'(fvld1), 32'd1);
    check_eq("alu_fwd_rd", 32'(frd1), 32'd3);
    check_eq("alu_fwd_data", 32'(fdat1), 32'h2A);
`endif
    tick();
    drive_idle();
    check_eq("alu_we", 32'(we1), 32'd1);
    check_eq("alu_waddr", 32'(waddr1), 32'd3);
    check_eq("alu_wdata", 32'(wdata1), 32'h2A);
    tick();
    check_eq("bubble_we", 32'(we1), 32'd0);
    check_eq("bubble_wdata_hold", 32'(wdata1), 32'h2A);
    check_eq("bubble_waddr_hold", 32'(waddr1), 32'd3);

    // Store 0x5C to 0x17 (aliases to 7), regwr=0: no write-back.
    drive(1'b1, 8'h17, 8'h5C, 3'd4, 1'b0, 1'b1, 1'b0);
    run_memop("st7", 1'b0, 1);
    drive_idle();
    check_eq("st7_we", 32'(we1), 32'd0);

    // Load address 7 into rd=1.
    drive(1'b1, 8'h07, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
`ifdef MEM_FWD_EN
    #1;
    check_eq("ld_fwd_valid", 32'(fvld1), 32'd0);
`endif
    run_memop("ld7", 1'b0, 1);
    drive_idle();
    check_eq("ld7_we", 32'(we1), 32'd1);
    check_eq("ld7_waddr", 32'(waddr1), 32'd1);
    check_eq("ld7_wdata", 32'(wdata1), 32'h5C);

    // memrd+memwr together is a store; write-back data is the ALU result.
    // Followed back-to-back by a load of the same address.
    drive(1'b1, 8'h33, 8'hA5, 3'd6, 1'b1, 1'b1, 1'b1);
    run_memop("rw3", 1'b0, 1);
    check_eq("rw3_we", 32'(we1), 32'd1);
    check_eq("rw3_waddr", 32'(waddr1), 32'd6);
    check_eq("rw3_wdata", 32'(wdata1), 32'h33);
    drive(1'b1, 8'h03, 8'h00, 3'd5, 1'b1, 1'b0, 1'b1);
    run_memop("b2b_ld3", 1'b0, 1);
    drive_idle();
    check_eq("b2b_ld3_we", 32'(we1), 32'd1);
    check_eq("b2b_ld3_waddr", 32'(waddr1), 32'd5);
    check_eq("b2b_ld3_wdata", 32'(wdata1), 32'hA5);

    // Reset during BUSY aborts the store to address 2.
    drive(1'b1, 8'h02, 8'hFF, 3'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check_eq("abort_stall_pre", 32'(stall1), 32'd1);
    tick();
    drive_idle();
    reset_n = 1'b0;
    #1;
    check_eq("abort_stall_rst", 32'(stall1), 32'd0);
    check_eq("abort_we_rst", 32'(we1), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    // A memop presented now must stall at once, proving the FSM is IDLE.
    drive(1'b1, 8'h02, 8'h00, 3'd7, 1'b1, 1'b0, 1'b1);
    run_memop("abort_ld2", 1'b0, 1);
    drive_idle();
    check_eq("abort_ld2_we", 32'(we1), 32'd1);
    check_eq("abort_ld2_wdata", 32'(wdata1), 32'h00);

    // WAIT_CYCLES=3 instance.
    do_reset();
    drive(1'b1, 8'h09, 8'h77, 3'd0, 1'b0, 1'b1, 1'b0);
    run_memop("w3_st9", 1'b1, 3);
    drive_idle();
    check_eq("w3_st9_we", 32'(we3), 32'd0);

    // Load 9 while changing the inputs during BUSY to a conflicting store.
    drive(1'b1, 8'h09, 8'h00, 3'd5, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("w3_ld_stall_c0", 32'(stall3), 32'd1);
    tick();
    drive(1'b1, 8'h19, 8'h00, 3'd7, 1'b0, 1'b1, 1'b1);
    #1;
    check_eq("w3_ld_stall_c1", 32'(stall3), 32'd1);
    check_eq("w3_ld_we_c1", 32'(we3), 32'd0);
    tick();
    check_eq("w3_ld_stall_c2", 32'(stall3), 32'd1);
    check_eq("w3_ld_we_c2", 32'(we3), 32'd0);
    tick();
    check_eq("w3_ld_stall_c3", 32'(stall3), 32'd0);
    check_eq("w3_ld_we_c3", 32'(we3), 32'd0);
    tick();
    drive_idle();
    check_eq("w3_ld_we", 32'(we3), 32'd1);
    check_eq("w3_ld_waddr", 32'(waddr3), 32'd5);
    check_eq("w3_ld_wdata", 32'(wdata3), 32'h77);
    tick();
    check_eq("w3_ld_we_pulse", 32'(we3), 32'd0);

    // The ignored store must not have touched address 9.
    drive(1'b1, 8'h09, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
    run_memop("w3_reld9", 1'b1, 3);
    drive_idle();
    check_eq("w3_reld9_wdata", 32'(wdata3), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the 8-bit RISC pipeline. It sits directly downstream of the EXE/MEM register and consumes its `exe_mem_out` result plus the instruction's control bits. It holds a small data memory with a configurable number of wait states, and stalls upstream while an access is in flight. It drives the registered MEM/WB outputs that write the register file.

## Interface
Parameters:
- `DATA_W`, 8, datapath width.
- `ADDR_W`, 4, data-memory address width; depth is 2^ADDR_W words.
- `RADDR_W`, 3, register-file address width.
- `WAIT_CYCLES`, 1, extra cycles per load or store. Legal range is 0..7.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `exe_mem_valid`  in  1  EXE/MEM holds a real instruction.
- `exe_mem_out`  in  DATA_W  ALU result; its low ADDR_W bits are the memory address for loads and stores.
- `exe_mem_sdata`  in  DATA_W  store data.
- `exe_mem_rd`  in  RADDR_W  destination register.
- `exe_mem_memrd`  in  1  load.
- `exe_mem_memwr`  in  1  store.
- `exe_mem_regwr`  in  1  instruction writes the register file.
- `mem_stall`  out  1  combinational; while high, upstream must hold EXE/MEM.
- `rf_we`  out  1  registered register-file write enable.
- `rf_waddr`  out  RADDR_W  registered write address.
- `rf_wdata`  out  DATA_W  registered write data.

## Operation
Terms:
- A "memop" is `exe_mem_valid & (exe_mem_memrd | exe_mem_memwr)`.
- The `rf_we`/`rf_waddr`/`rf_wdata` triple is the MEM/WB register.

FSM has two states, IDLE and BUSY, plus a down-counter `cnt` (3 bits).

IDLE:
- Not valid → bubble: `rf_we`<=0; `rf_waddr` and `rf_wdata` hold.
- Valid, not a memop → `rf_we`<=`exe_mem_regwr`, `rf_waddr`<=`exe_mem_rd`, `rf_wdata`<=`exe_mem_out`.
- Memop with WAIT_CYCLES=0 → access in the same edge:
  - Store: mem[addr]<=`sdata`.
  - Load: `rf_wdata`<=mem[addr].
  - `rf_we`<=`regwr`.
- Memop with WAIT_CYCLES>0:
  - Latch addr, sdata, rd, memrd, memwr and regwr into an op register.
  - `cnt`<=WAIT_CYCLES-1, go to BUSY, `rf_we`<=0.

BUSY:
- EXE/MEM inputs are ignored.
- `cnt`≠0 → `cnt`<=`cnt`-1, `rf_we`<=0.
- `cnt`=0 → perform the latched access, update MEM/WB as in the WAIT_CYCLES=0 case, go to IDLE.

Rules:
- `mem_stall` = (IDLE & memop & WAIT_CYCLES>0) | (BUSY & `cnt`≠0).
- memrd and memwr both set → store only; write-back data is `exe_mem_out`.
- A load with regwr=0 performs the read and produces no write-back.
- Address upper bits (`exe_mem_out[DATA_W-1:ADDR_W]`) are ignored; addresses wrap modulo 2^ADDR_W.
- `rf_we` is not suppressed for rd=0; the register file owns that rule.

## Timing
- Non-memop: 1-cycle latency, presented in cycle n → visible on the `rf_*` outputs after edge n.
- Memop: WAIT_CYCLES+1 cycle latency; `mem_stall` is high for exactly WAIT_CYCLES consecutive cycles, starting in the presentation cycle.
- The memory write happens on the completion edge only; a store never becomes visible earlier.
- Back-to-back memops: the second is accepted in the IDLE cycle after completion, so there are no idle gaps beyond the stall.
- Reset (`reset_n` low, asynchronous):
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, state=IDLE, `cnt`=0, `mem_stall`=0.
  - Data memory is cleared to 0.
- Reset during BUSY aborts the op with no memory write; after release the stage is IDLE.

## Configuration
- `MEM_FWD_EN` defined → adds the forwarding outputs `fwd_valid` (1), `fwd_rd` (RADDR_W) and `fwd_data` (DATA_W), all combinational.
  - `fwd_valid` = IDLE & `exe_mem_valid` & `exe_mem_regwr` & !`exe_mem_memrd`.
  - `fwd_rd` = `exe_mem_rd`; `fwd_data` = `exe_mem_out`.
  - This lets EXE bypass ALU results one cycle early.
- `MEM_FWD_EN` undefined → these ports and their logic do not exist; all other behaviour is identical.

## Test plan
All scenarios use WAIT_CYCLES=1 unless stated.
- Reset: hold `reset_n`=0 for 2 cycles, release → all `rf_*` outputs 0, `mem_stall`=0; a load from address 5 returns 0x00.
- ALU op: valid, regwr=1, rd=3, out=0x2A → after 1 edge `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x2A; `mem_stall` stays 0.
- Store then load:
  - Store 0x5C to address 0x17, which aliases to 7: `mem_stall` is high for 1 cycle and `rf_we` is 0 throughout.
  - Then load from address 7 to rd=1: after 2 edges `rf_we`=1, `rf_wdata`=0x5C.
- Wait states: WAIT_CYCLES=3, load → `mem_stall` high for exactly 3 cycles; `rf_we` pulses once on the 4th edge; changing the inputs during BUSY has no effect.
- Reset mid-op: store 0xFF to address 2, assert `reset_n` during BUSY → no write occurs (a later load from address 2 returns 0x00), and the FSM is IDLE.
- `MEM_FWD_EN`: ALU op rd=4, out=0x11 → `fwd_valid`=1, `fwd_rd`=4, `fwd_data`=0x11 in the same cycle; `fwd_valid`=0 for a load.
